// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the ID/EX/WB RV32 pipeline: operand forwarding,
// load-use stalls, redirect flushes and data-memory wait freezes.
module pipeline_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  RAddr1_ID,
  input  logic [4:0]  RAddr2_ID,
  input  logic        uses_rs1_ID,
  input  logic        uses_rs2_ID,
  input  logic [4:0]  WAddr_ID,
  input  logic        WrEn_RF_ID,
  input  logic        is_load_ID,
  input  logic        PC_Mux_EX,
  input  logic        dm_req_EX,
  input  logic        dm_ready,
  output logic [1:0]  ALU_hazmux1_sel_ID,
  output logic [1:0]  ALU_hazmux2_sel_ID,
  output logic        stall_pc,
  output logic        stall_id,
  output logic        stall_ex,
  output logic        bubble_ex,
  output logic        flush_id,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_t;

  state_t      state, state_nxt, saved, saved_nxt, eff_state;
  logic [2:0]  cnt, cnt_nxt;
  logic        ex_vld, ex_load, wb_vld;
  logic [4:0]  ex_waddr, wb_waddr;
  logic        freeze, in_flush, redirect, flush_act, lu_raw, lu;

  function automatic logic [1:0] fwd_sel(input logic [4:0] raddr,
                                         input logic ev, input logic [4:0] ea,
                                         input logic wv, input logic [4:0] wa);
    if (ev && ea != 5'd0 && ea == raddr)      return 2'b01;
    else if (wv && wa != 5'd0 && wa == raddr) return 2'b10;
    else                                      return 2'b00;
  endfunction

  always_comb begin
    freeze    = (dm_req_EX & ~dm_ready) | ((state == MEM_WAIT) & ~dm_ready);
    // a wait entered from FLUSH keeps squashing ID until the flush completes
    in_flush  = (state == FLUSH) | ((state == MEM_WAIT) & (saved == FLUSH));
    redirect  = PC_Mux_EX & ~freeze;
    flush_act = in_flush | redirect;
    lu_raw    = ex_vld & ex_load & (ex_waddr != 5'd0) &
                ((uses_rs1_ID & (RAddr1_ID == ex_waddr)) |
                 (uses_rs2_ID & (RAddr2_ID == ex_waddr)));
    lu        = lu_raw & ~freeze & ~flush_act;

    ALU_hazmux1_sel_ID = 2'b00;
    ALU_hazmux2_sel_ID = 2'b00;
    stall_pc  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    bubble_ex = 1'b1;
    flush_id  = 1'b1;
    if (!reset) begin
      ALU_hazmux1_sel_ID = fwd_sel(RAddr1_ID, ex_vld, ex_waddr, wb_vld, wb_waddr);
      ALU_hazmux2_sel_ID = fwd_sel(RAddr2_ID, ex_vld, ex_waddr, wb_vld, wb_waddr);
      stall_pc  = freeze | lu;
      stall_id  = freeze | lu;
      stall_ex  = freeze;
      bubble_ex = ~freeze & (flush_act | lu);
      flush_id  = in_flush | redirect;
    end
  end

  always_comb begin
    state_nxt = state;
    saved_nxt = saved;
    cnt_nxt   = cnt;
    // the release cycle of a wait behaves as the state the wait interrupted
    eff_state = (state == MEM_WAIT) ? saved : state;
    if (freeze) begin
      if (state != MEM_WAIT) begin
        saved_nxt = state;
        state_nxt = MEM_WAIT;
      end
    end else begin
      state_nxt = eff_state;
      if (PC_Mux_EX) begin
        cnt_nxt   = 3'(FLUSH_CYCLES - 1);
        state_nxt = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
      end else if (eff_state == FLUSH) begin
        if (cnt <= 3'd1) begin
          cnt_nxt   = 3'd0;
          state_nxt = RUN;
        end else begin
          cnt_nxt = cnt - 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      saved       <= RUN;
      cnt         <= 3'd0;
      ex_vld      <= 1'b0;
      ex_load     <= 1'b0;
      wb_vld      <= 1'b0;
      stall_count <= 32'd0;
    end else begin
      state <= state_nxt;
      saved <= saved_nxt;
      cnt   <= cnt_nxt;
      if (!freeze) begin
        ex_vld  <= WrEn_RF_ID & ~bubble_ex & ~flush_id;
        ex_load <= is_load_ID;
        wb_vld  <= ex_vld;
      end
      if (stall_pc && stall_count != 32'hFFFF_FFFF)
        stall_count <= stall_count + 32'd1;
    end
  end

  // register numbers are meaningless without their valid bits, so they carry no reset
  always_ff @(posedge clk) begin
    if (!freeze) begin
      ex_waddr <= WAddr_ID;
      wb_waddr <= ex_waddr;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: a cycle-by-cycle vector table plus
// hand-written asynchronous-reset sequences.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  RAddr1_ID, RAddr2_ID, WAddr_ID;
  logic        uses_rs1_ID, uses_rs2_ID, WrEn_RF_ID, is_load_ID;
  logic        PC_Mux_EX, dm_req_EX, dm_ready;
  logic [1:0]  ALU_hazmux1_sel_ID, ALU_hazmux2_sel_ID;
  logic        stall_pc, stall_id, stall_ex, bubble_ex, flush_id;
  logic [31:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .RAddr1_ID(RAddr1_ID), .RAddr2_ID(RAddr2_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .WAddr_ID(WAddr_ID), .WrEn_RF_ID(WrEn_RF_ID), .is_load_ID(is_load_ID),
    .PC_Mux_EX(PC_Mux_EX), .dm_req_EX(dm_req_EX), .dm_ready(dm_ready),
    .ALU_hazmux1_sel_ID(ALU_hazmux1_sel_ID), .ALU_hazmux2_sel_ID(ALU_hazmux2_sel_ID),
    .stall_pc(stall_pc), .stall_id(stall_id), .stall_ex(stall_ex),
    .bubble_ex(bubble_ex), .flush_id(flush_id), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2, wa;
    logic        u1, u2, we, ld, pcm, req, rdy;
    logic [8:0]  outs;   // {sel1, sel2, stall_pc, stall_id, stall_ex, bubble_ex, flush_id}
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(int rs1, int rs2, int u1, int u2, int wa, int we, int ld,
                              int pcm, int req, int rdy, int s1, int s2,
                              int spc, int sid, int sex, int bub, int fl, int cnt);
    vec_t v;
    v.rs1 = 5'(rs1); v.rs2 = 5'(rs2); v.u1 = 1'(u1); v.u2 = 1'(u2);
    v.wa = 5'(wa); v.we = 1'(we); v.ld = 1'(ld);
    v.pcm = 1'(pcm); v.req = 1'(req); v.rdy = 1'(rdy);
    v.outs = {2'(s1), 2'(s2), 1'(spc), 1'(sid), 1'(sex), 1'(bub), 1'(fl)};
    v.cnt = 32'(cnt);
    return v;
  endfunction

  function automatic logic [8:0] outs_now();
    return {ALU_hazmux1_sel_ID, ALU_hazmux2_sel_ID, stall_pc, stall_id, stall_ex,
            bubble_ex, flush_id};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    RAddr1_ID = v.rs1; RAddr2_ID = v.rs2; uses_rs1_ID = v.u1; uses_rs2_ID = v.u2;
    WAddr_ID = v.wa; WrEn_RF_ID = v.we; is_load_ID = v.ld;
    PC_Mux_EX = v.pcm; dm_req_EX = v.req; dm_ready = v.rdy;
  endtask

  initial begin
    //           rs1 rs2 u1 u2 wa we ld pcm req rdy s1 s2 spc sid sex bub fl cnt
    vq.push_back(mk( 1,  2, 1, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 5,  6, 1, 1,  6, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 5,  6, 1, 1,  0, 1, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0,  6, 1, 1,  9, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 0,  0, 1, 1,  9, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 9,  9, 1, 1,  7, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk( 9,  7, 1, 1,  8, 1, 0, 0, 0, 0, 2, 1, 1, 1, 0, 1, 0, 0));
    vq.push_back(mk( 9,  7, 1, 1,  8, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk( 8,  0, 0, 0,  3, 1, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk( 3,  3, 0, 0,  0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk( 0,  0, 0, 0,  4, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk( 4,  0, 1, 0, 11, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 1, 1));
    vq.push_back(mk( 4,  0, 1, 0, 12, 1, 1, 0, 0, 0, 2, 0, 0, 0, 0, 1, 1, 1));
    vq.push_back(mk(12,  0, 1, 0, 13, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(13,  0, 1, 0, 14, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 1));
    vq.push_back(mk(13,  0, 1, 0, 14, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 2));
    vq.push_back(mk(13,  0, 1, 0, 14, 1, 0, 0, 1, 0, 1, 0, 1, 1, 1, 0, 0, 3));
    vq.push_back(mk(13,  0, 1, 0, 14, 1, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 4));
    vq.push_back(mk(13, 14, 1, 1,  0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 0, 0, 4));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 4));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 1, 0, 1, 5));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 1, 6));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 6));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 7));
    vq.push_back(mk( 0,  0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 7));
    vq.push_back(mk( 0,  0, 0, 0,  7, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    vq.push_back(mk( 0,  7, 0, 1,  8, 1, 0, 0, 1, 0, 0, 1, 1, 1, 1, 0, 0, 7));
    vq.push_back(mk( 0,  7, 0, 1,  8, 1, 0, 0, 1, 1, 0, 1, 1, 1, 0, 1, 0, 8));
    vq.push_back(mk( 0,  7, 0, 1,  8, 1, 0, 0, 0, 0, 0, 2, 0, 0, 0, 0, 0, 9));

    // reset state, with freeze and redirect inputs active
    reset = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("reset_outs", 32'(outs_now()), 32'(9'b0000_00011));
    chk("reset_cnt", stall_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d_outs", i), 32'(outs_now()), 32'(vq[i].outs));
      chk($sformatf("v%0d_cnt", i), stall_count, vq[i].cnt);
    end

    // async reset in the middle of a memory wait (EX holds a valid x8)
    @(negedge clk);
    drive(mk(8, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mw_enter", 32'(outs_now()), 32'(9'b01_00_11100));
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("mw_reset_outs", 32'(outs_now()), 32'(9'b00_00_00011));
    chk("mw_reset_cnt", stall_count, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(mk(8, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("mw_after_outs", 32'(outs_now()), 32'(9'b0));
    @(negedge clk);
    #1;
    chk("mw_after2_outs", 32'(outs_now()), 32'(9'b0));
    chk("mw_after2_cnt", stall_count, 32'd0);

    // async reset in the middle of a flush
    @(negedge clk);
    drive(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #2;
    PC_Mux_EX = 1'b0;
    reset = 1'b1;
    #1;
    chk("fl_reset_outs", 32'(outs_now()), 32'(9'b00_00_00011));
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("fl_after_outs", 32'(outs_now()), 32'(9'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
